line_word_stream: RTL and testbench

Parametrised, sequential line/word converter for the LC-3b cache datapath. The split channel accepts a full cache line and streams its words out one per handshake, critical-word-first with wrap-around. The pack channel collects indexed words, in any order, into a full line and presents it once every slot is written. It sits between the cache line array and word-wide consumers/producers (CPU port, memory interface) where a combinational word split is not enough.

---
 rtl/line_word_stream.sv | 159 +++++++++++++++
 tb/tb_line_word_stream.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_word_stream.sv
// line_word_stream
//   Line/word converter for the cache datapath.
//   Split channel: accepts a full cache line and streams its words one per
//   handshake, critical-word-first (start_idx), wrapping past the last word.
//   Pack channel: collects indexed words in any order into a full line and
//   presents it once every slot has been written at least once.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   line_in/line_valid/start_idx/line_ready     split line input
//   word_out/word_idx/word_last/word_valid/word_ready   split word output
//   word_in/word_in_idx/word_in_valid/word_in_ready     pack word input
//   pack_clear      synchronous abort of the pack channel
//   line_out/line_out_valid/line_out_ready      packed line output
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A producer holds its payload stable while valid && !ready. Every ready and
// valid output here is decoded from registered state only, so no input
// reaches any output combinationally. The two channels share nothing.
module line_word_stream #(
  parameter int WORD_W = 16,
  parameter int NWORDS = 8,
  localparam int LINE_W = WORD_W * NWORDS,
  localparam int IDX_W  = $clog2(NWORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_in,
  input  logic              line_valid,
  input  logic [IDX_W-1:0]  start_idx,
  output logic              line_ready,
  output logic [WORD_W-1:0] word_out,
  output logic [IDX_W-1:0]  word_idx,
  output logic              word_last,
  output logic              word_valid,
  input  logic              word_ready,
  input  logic [WORD_W-1:0] word_in,
  input  logic [IDX_W-1:0]  word_in_idx,
  input  logic              word_in_valid,
  output logic              word_in_ready,
  input  logic              pack_clear,
  output logic [LINE_W-1:0] line_out,
  output logic              line_out_valid,
  input  logic              line_out_ready
);

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NWORDS - 1);

  // ---------------------------------------------------------------- split
  typedef enum logic {S_IDLE, S_STREAM} split_state_t;

  split_state_t      s_state, s_next;
  logic [LINE_W-1:0] buffer;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  cnt;   // words already handed out for this line
  logic              line_take;
  logic              word_take;

  always_comb begin
    s_next    = s_state;
    line_take = 1'b0;
    word_take = 1'b0;
    case (s_state)
      S_IDLE: begin
        if (line_valid) begin
          line_take = 1'b1;
          s_next    = S_STREAM;
        end
      end
      S_STREAM: begin
        if (word_ready) begin
          word_take = 1'b1;
          if (cnt == LAST_CNT) s_next = S_IDLE;
        end
      end
      default: s_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_state <= S_IDLE;
      buffer  <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      s_state <= s_next;
      if (line_take) begin
        buffer <= line_in;
        ptr    <= start_idx;
        cnt    <= '0;
      end else if (word_take) begin
        // ptr wraps naturally because NWORDS is a power of two
        ptr <= ptr + 1'b1;
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign line_ready = (s_state == S_IDLE);
  assign word_valid = (s_state == S_STREAM);
  assign word_out   = buffer[int'(ptr)*WORD_W +: WORD_W];
  assign word_idx   = ptr;
  assign word_last  = (s_state == S_STREAM) && (cnt == LAST_CNT);

  // ----------------------------------------------------------------- pack
  typedef enum logic {P_FILL, P_FULL} pack_state_t;

  pack_state_t       p_state, p_next;
  logic [NWORDS-1:0] mask, mask_next;
  logic [LINE_W-1:0] slots;
  logic              slot_we;

  always_comb begin
    p_next    = p_state;
    mask_next = mask;
    slot_we   = 1'b0;
    if (pack_clear) begin
      // abort wins over a same-cycle write and drops any held line
      p_next    = P_FILL;
      mask_next = '0;
    end else begin
      case (p_state)
        P_FILL: begin
          if (word_in_valid) begin
            slot_we   = 1'b1;
            // rewriting a set slot leaves the mask unchanged
            mask_next = mask | (NWORDS'(1) << word_in_idx);
            if (&mask_next) p_next = P_FULL;
          end
        end
        P_FULL: begin
          if (line_out_ready) begin
            mask_next = '0;
            p_next    = P_FILL;
          end
        end
        default: p_next = P_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state <= P_FILL;
      mask    <= '0;
      slots   <= '0;
    end else begin
      p_state <= p_next;
      mask    <= mask_next;
      if (slot_we) slots[int'(word_in_idx)*WORD_W +: WORD_W] <= word_in;
    end
  end

  assign word_in_ready  = (p_state == P_FILL);
  assign line_out_valid = (p_state == P_FULL);
  assign line_out       = slots;

endmodule

// File: tb/tb_line_word_stream.sv
module tb_line_word_stream;
  localparam int WORD_W = 16;
  localparam int NWORDS = 8;
  localparam int IDX_W  = 3;
  localparam int LINE_W = WORD_W * NWORDS;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [LINE_W-1:0] line_in = '0;
  logic              line_valid = 1'b0;
  logic [IDX_W-1:0]  start_idx = '0;
  logic              line_ready;
  logic [WORD_W-1:0] word_out;
  logic [IDX_W-1:0]  word_idx;
  logic              word_last;
  logic              word_valid;
  logic              word_ready = 1'b0;
  logic [WORD_W-1:0] word_in = '0;
  logic [IDX_W-1:0]  word_in_idx = '0;
  logic              word_in_valid = 1'b0;
  logic              word_in_ready;
  logic              pack_clear = 1'b0;
  logic [LINE_W-1:0] line_out;
  logic              line_out_valid;
  logic              line_out_ready = 1'b0;

  line_word_stream #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
    .clk(clk), .rst(rst),
    .line_in(line_in), .line_valid(line_valid), .start_idx(start_idx),
    .line_ready(line_ready),
    .word_out(word_out), .word_idx(word_idx), .word_last(word_last),
    .word_valid(word_valid), .word_ready(word_ready),
    .word_in(word_in), .word_in_idx(word_in_idx), .word_in_valid(word_in_valid),
    .word_in_ready(word_in_ready), .pack_clear(pack_clear),
    .line_out(line_out), .line_out_valid(line_out_valid),
    .line_out_ready(line_out_ready)
  );

  // ------------------------------------------------------------ checking
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ----------------------------------------------------- reference model
  // Split: each accepted line becomes a queue of the words it must emit.
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] w;
    logic              last;
  } exp_t;
  exp_t exp_q[$];

  // Pack: slot contents, which slots are written, and whether a line is held.
  logic [WORD_W-1:0] pk_slot [NWORDS];
  bit                pk_mask [NWORDS];
  bit                pk_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      pk_full = 0;
      for (int k = 0; k < NWORDS; k++) begin
        pk_mask[k] = 0;
        pk_slot[k] = '0;
      end
    end else begin
      if (exp_q.size() != 0) begin
        if (word_ready) void'(exp_q.pop_front());
      end else if (line_valid) begin
        for (int k = 0; k < NWORDS; k++) begin
          exp_t e;
          int   j;
          j      = (int'(start_idx) + k) % NWORDS;
          e.idx  = IDX_W'(j);
          e.w    = line_in[j*WORD_W +: WORD_W];
          e.last = (k == NWORDS - 1);
          exp_q.push_back(e);
        end
      end

      if (pack_clear) begin
        pk_full = 0;
        for (int k = 0; k < NWORDS; k++) pk_mask[k] = 0;
      end else if (!pk_full) begin
        if (word_in_valid) begin
          bit all;
          pk_slot[word_in_idx] = word_in;
          pk_mask[word_in_idx] = 1;
          all = 1;
          for (int k = 0; k < NWORDS; k++) all = all & pk_mask[k];
          pk_full = all;
        end
      end else if (line_out_ready) begin
        pk_full = 0;
        for (int k = 0; k < NWORDS; k++) pk_mask[k] = 0;
      end
    end
  end

  // Continuous scoreboard, sampled on the falling edge.
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("line_ready", line_ready, exp_q.size() == 0);
      check("word_valid", word_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("word_out", word_out, exp_q[0].w);
        check("word_idx", word_idx, exp_q[0].idx);
        check("word_last", word_last, exp_q[0].last);
      end
      check("word_in_ready", word_in_ready, !pk_full);
      check("line_out_valid", line_out_valid, pk_full);
      if (pk_full) begin
        logic [LINE_W-1:0] exp_line;
        for (int k = 0; k < NWORDS; k++) exp_line[k*WORD_W +: WORD_W] = pk_slot[k];
        check("line_out", line_out, exp_line);
      end
    end
  end

  // --------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_write(input int idx, input logic [WORD_W-1:0] w);
    word_in_idx   = IDX_W'(idx);
    word_in       = w;
    word_in_valid = 1'b1;
    tick();
    word_in_valid = 1'b0;
  endtask

  localparam logic [LINE_W-1:0] LINE_A =
    128'h8888_7777_6666_5555_4444_3333_2222_1111;

  initial begin
    int cycles;

    // reset values
    tick();
    tick();
    check("rst_line_ready", line_ready, 1'b1);
    check("rst_word_valid", word_valid, 1'b0);
    check("rst_word_out", word_out, '0);
    check("rst_word_idx", word_idx, '0);
    check("rst_word_last", word_last, 1'b0);
    check("rst_word_in_ready", word_in_ready, 1'b1);
    check("rst_line_out_valid", line_out_valid, 1'b0);
    check("rst_line_out", line_out, '0);
    rst = 1'b0;
    chk_en = 1;
    tick();

    // split in order, word_ready held high
    line_in = LINE_A; start_idx = 3'd0; line_valid = 1'b1; word_ready = 1'b1;
    tick();
    line_valid = 1'b0;
    check("inorder_first", word_out, 16'h1111);
    cycles = 0;
    while (!line_ready && cycles < 20) begin
      tick();
      cycles++;
    end
    check("inorder_gap", cycles, NWORDS);

    // split wrap with backpressure
    line_in = LINE_A; start_idx = 3'd5; line_valid = 1'b1; word_ready = 1'b0;
    tick();
    line_valid = 1'b0;
    check("wrap_first_word", word_out, 16'h6666);
    check("wrap_first_idx", word_idx, 3'd5);
    cycles = 0;
    while (!line_ready && cycles < 40) begin
      word_ready = ~word_ready;
      tick();
      cycles++;
    end
    check("wrap_done", line_ready, 1'b1);
    word_ready = 1'b0;

    // reset mid-stream
    line_in = {$urandom, $urandom, $urandom, $urandom};
    start_idx = 3'd4; line_valid = 1'b1; word_ready = 1'b1;
    tick();
    line_valid = 1'b0;
    tick(); tick(); tick();
    word_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_word_valid", word_valid, 1'b0);
    check("midrst_line_ready", line_ready, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    line_in = LINE_A; start_idx = 3'd2; line_valid = 1'b1; word_ready = 1'b1;
    tick();
    line_valid = 1'b0;
    check("postrst_idx", word_idx, 3'd2);
    check("postrst_word", word_out, 16'h3333);
    cycles = 0;
    while (!line_ready && cycles < 20) begin
      tick();
      cycles++;
    end
    check("postrst_gap", cycles, NWORDS);
    word_ready = 1'b0;

    // pack out of order with a duplicate slot
    for (int i = 7; i >= 4; i--) pack_write(i, 16'hA000 + 16'(i));
    pack_write(3, 16'hBEEF);
    pack_write(3, 16'hA003);
    pack_write(2, 16'hA002);
    pack_write(1, 16'hA001);
    check("pack_not_yet", line_out_valid, 1'b0);
    pack_write(0, 16'hA000);
    check("pack_full", line_out_valid, 1'b1);
    check("pack_slot3", line_out[3*WORD_W +: WORD_W], 16'hA003);
    tick(); tick();
    check("pack_hold_ready", word_in_ready, 1'b0);
    line_out_ready = 1'b1;
    tick();
    line_out_ready = 1'b0;
    check("pack_taken", word_in_ready, 1'b1);

    // pack_clear concurrent with the completing word
    for (int i = 0; i < 7; i++) pack_write(i, 16'($urandom));
    pack_clear = 1'b1;
    pack_write(7, 16'h7777);
    pack_clear = 1'b0;
    tick();
    check("clear_no_line", line_out_valid, 1'b0);
    for (int i = 0; i < 8; i++) pack_write(i, 16'($urandom));
    check("clear_refill", line_out_valid, 1'b1);
    line_out_ready = 1'b1;
    tick();
    line_out_ready = 1'b0;

    // both channels together, random traffic
    for (int c = 0; c < 3000; c++) begin
      line_valid     = ($urandom_range(0, 3) != 0);
      line_in        = {$urandom, $urandom, $urandom, $urandom};
      start_idx      = IDX_W'($urandom_range(0, NWORDS - 1));
      word_ready     = ($urandom_range(0, 2) != 0);
      word_in_valid  = ($urandom_range(0, 1) != 0);
      word_in_idx    = IDX_W'($urandom_range(0, NWORDS - 1));
      word_in        = 16'($urandom);
      pack_clear     = ($urandom_range(0, 40) == 0);
      line_out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    line_valid = 1'b0; word_in_valid = 1'b0; pack_clear = 1'b0;
    tick();
    chk_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
